demux_16w_1_to_8_buf: RTL

- Buffered 1-to-8 demultiplexer for 16-bit words; the write-side counterpart of the 16-wide 8-to-1 select mux in the ProjectB datapath.
- Takes one producer word plus a 3-bit destination select and latches it into one of eight output holding registers.
- Each holding register has a valid/ack handshake toward its consumer.
- The producer side stalls through InReady when the addressed slot is still occupied.

---
 rtl/demux_pkg.sv | 26 ++
 rtl/demux_16w_1_to_8_buf_if.sv | 35 +++
 rtl/demux_slot.sv | 36 +++
 rtl/demux_16w_1_to_8_buf.sv | 63 ++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1-to-8 word demultiplexer.
//   WIDTH  - data width of the input word and of each holding register
//   NCH    - number of output channels (fixed at 8)
//   SEL_W  - width of the destination select {S2,S1,S0}
//   word_t - one data word
//   ch_e   - channel names; the value is the select code for that channel
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [SEL_W-1:0] {
    CH_R = 3'd0,
    CH_S = 3'd1,
    CH_T = 3'd2,
    CH_U = 3'd3,
    CH_V = 3'd4,
    CH_W = 3'd5,
    CH_X = 3'd6,
    CH_Y = 3'd7
  } ch_e;

endpackage

// File: rtl/demux_16w_1_to_8_buf_if.sv
// Producer/consumer bus of the buffered 1-to-8 demultiplexer.
//   D, S0..S2, InValid, Clear, Ack : driven by the producer/consumers (master)
//   InReady, R..Y, Valid, WrCount  : driven by the demultiplexer (slave)
//
// Handshake: a producer word is transferred on a rising Clock edge where
// InValid and InReady are both high. While InValid is high and InReady is
// low the producer holds D (it may change the select). Channel i is held
// by its consumer while Valid[i] is high; an edge with Ack[i] & Valid[i]
// frees the slot. Ack[i] with Valid[i] low has no effect.
interface demux_16w_1_to_8_buf_if;
  import demux_pkg::*;

  word_t          D;
  logic           S0;
  logic           S1;
  logic           S2;
  logic           InValid;
  logic           InReady;
  logic           Clear;
  word_t          R, S, T, U, V, W, X, Y;
  logic [NCH-1:0] Valid;
  logic [NCH-1:0] Ack;
  logic [7:0]     WrCount;

  modport master (
    output D, S0, S1, S2, InValid, Clear, Ack,
    input  InReady, R, S, T, U, V, W, X, Y, Valid, WrCount
  );

  modport slave (
    input  D, S0, S1, S2, InValid, Clear, Ack,
    output InReady, R, S, T, U, V, W, X, Y, Valid, WrCount
  );

endinterface

// File: rtl/demux_slot.sv
// One output channel: a data holding register plus its occupied flag.
//   Clock, ResetN : clock and asynchronous active-low reset
//   load          : capture d and mark the slot occupied
//   ack           : consumer has taken the word; frees the slot
//   clear         : flush the occupied flag (data is kept)
//   d             : word to capture
//   q, valid      : held word and occupied flag
module demux_slot
  import demux_pkg::*;
(
  input  logic  Clock,
  input  logic  ResetN,
  input  logic  load,
  input  logic  ack,
  input  logic  clear,
  input  word_t d,
  output word_t q,
  output logic  valid
);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      // Data is only ever replaced by a new load; release leaves it in place.
      if (load) q <= d;
      // Load wins over ack so an ack and a new word on the same edge give
      // a back-to-back pass-through. The top never loads while clear is high.
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      else if (ack)  valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_16w_1_to_8_buf.sv
// Buffered 1-to-8 demultiplexer for 16-bit words. A producer word is
// written into the holding register picked by {S2,S1,S0}; each register
// is handed to its consumer with a Valid/Ack pair. The producer stalls via
// InReady while the addressed slot is still occupied and not being acked.
//   Clock, ResetN : rising-edge clock, asynchronous active-low reset
//   bus           : producer word/select/handshake, Clear, channel outputs
//                   R..Y (channels 0..7), Valid, Ack and WrCount
module demux_16w_1_to_8_buf
  import demux_pkg::*;
(
  input  logic                   Clock,
  input  logic                   ResetN,
  demux_16w_1_to_8_buf_if.slave  bus
);

  logic [SEL_W-1:0] sel;
  logic             accept;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   valid;
  word_t            q [NCH];
  logic [7:0]       wr_count;

  always_comb begin
    sel = {bus.S2, bus.S1, bus.S0};
  end

  // A slot can take a new word when it is empty or is being released on
  // this same edge. Clear and reset both block acceptance.
  assign bus.InReady = ResetN & ~bus.Clear & (~valid[sel] | bus.Ack[sel]);
  assign accept      = bus.InValid & bus.InReady;
  assign load        = accept ? (NCH'(1) << sel) : '0;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux_slot u_slot (
      .Clock  (Clock),
      .ResetN (ResetN),
      .load   (load[i]),
      .ack    (bus.Ack[i]),
      .clear  (bus.Clear),
      .d      (bus.D),
      .q      (q[i]),
      .valid  (valid[i])
    );
  end

  // Free-running count of accepted words; wraps silently at 256.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)     wr_count <= '0;
    else if (accept) wr_count <= wr_count + 8'd1;
  end

  assign bus.R       = q[CH_R];
  assign bus.S       = q[CH_S];
  assign bus.T       = q[CH_T];
  assign bus.U       = q[CH_U];
  assign bus.V       = q[CH_V];
  assign bus.W       = q[CH_W];
  assign bus.X       = q[CH_X];
  assign bus.Y       = q[CH_Y];
  assign bus.Valid   = valid;
  assign bus.WrCount = wr_count;

endmodule
